// File: rtl/vga_mem_pkg.sv
// vga_mem_pkg: shared pixel RAM types, widths and client IDs.
// Used by the RAM arbiter, the display fetch path and the writers.
package vga_mem_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 6;

  localparam int PIX_R_LSB = 4;
  localparam int PIX_G_LSB = 2;
  localparam int PIX_B_LSB = 0;

  typedef logic [DATA_W_DEF-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } wr_state_e;

  localparam logic CLI_WR0 = 1'b0;
  localparam logic CLI_WR1 = 1'b1;

  function automatic logic [1:0] pix_r(input pixel_t p);
    return p[PIX_R_LSB+:2];
  endfunction

  function automatic logic [1:0] pix_g(input pixel_t p);
    return p[PIX_G_LSB+:2];
  endfunction

  function automatic logic [1:0] pix_b(input pixel_t p);
    return p[PIX_B_LSB+:2];
  endfunction

  function automatic logic cli_other(input logic id);
    return ~id;
  endfunction

  function automatic wr_state_e gnt_state(input logic id);
    return (id == CLI_WR1) ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/vga_ram_arbiter_if.sv
// vga_ram_arbiter_if: display, writer and RAM-port bundle.
// master = surrounding system, slave = the arbiter.
interface vga_ram_arbiter_if
  import vga_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              ena;
  logic              disp_active;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_pixel;

  logic              wr0_req;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr0_gnt;

  logic              wr1_req;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              wr1_gnt;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output ena,
    output disp_active,
    output disp_addr,
    input  disp_pixel,
    output wr0_req,
    output wr0_addr,
    output wr0_data,
    input  wr0_gnt,
    output wr1_req,
    output wr1_addr,
    output wr1_data,
    input  wr1_gnt,
    input  ram_en,
    input  ram_we,
    input  ram_addr,
    input  ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  ena,
    input  disp_active,
    input  disp_addr,
    output disp_pixel,
    input  wr0_req,
    input  wr0_addr,
    input  wr0_data,
    output wr0_gnt,
    input  wr1_req,
    input  wr1_addr,
    input  wr1_data,
    output wr1_gnt,
    output ram_en,
    output ram_we,
    output ram_addr,
    output ram_wdata,
    input  ram_rdata
  );

endinterface

// File: rtl/vga_wr_rr_arbiter.sv
// vga_wr_rr_arbiter: round-robin writer arbiter, bounded bursts.
// Grants are combinational; adv=0 stalls all state.
module vga_wr_rr_arbiter
  import vga_mem_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adv,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic sel
);

  localparam int CW =
    (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_TOP =
    CW'(MAX_BURST - 1);

  wr_state_e     state_q;
  wr_state_e     state_d;
  logic          rr_q;
  logic          rr_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic          own_id;
  logic          hold;
  logic          g_vld;
  logic          g_id;
  logic          oth_req;
  logic [CW-1:0] cur;

  // Choose the writer served this cycle
  always_comb begin
    own_id = (state_q == GNT1);
    hold   = (state_q != IDLE) &&
             (own_id ? req1 : req0);
    g_vld  = 1'b0;
    g_id   = rr_q;
    unique case (1'b1)
      hold: begin
        g_vld = 1'b1;
        g_id  = own_id;
      end
      (!hold && req0 && req1): begin
        g_vld = 1'b1;
        g_id  = rr_q;
      end
      (!hold && req0 && !req1): begin
        g_vld = 1'b1;
        g_id  = CLI_WR0;
      end
      (!hold && !req0 && req1): begin
        g_vld = 1'b1;
        g_id  = CLI_WR1;
      end
      default: ;
    endcase
    cur     = hold ? cnt_q : '0;
    oth_req = (g_id == CLI_WR1) ? req0 : req1;
  end

  // Next state, round-robin pointer and burst count
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    if (adv) begin
      if (g_vld) begin
        rr_d = cli_other(g_id);
        if (cur == CNT_TOP && oth_req) begin
          state_d = gnt_state(cli_other(g_id));
          cnt_d   = '0;
        end else begin
          state_d = gnt_state(g_id);
          cnt_d   = (cur == CNT_TOP) ?
                    cur : cur + CW'(1);
        end
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= CLI_WR0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt0 = rst_n & adv & g_vld &
                (g_id == CLI_WR0);
  assign gnt1 = rst_n & adv & g_vld &
                (g_id == CLI_WR1);
  assign sel  = g_id;

endmodule

// File: rtl/vga_ram_arbiter.sv
// vga_ram_arbiter: shares the pixel RAM between scan-out and writers.
// Display reads win outright; writers round-robin in blanking.
module vga_ram_arbiter
  import vga_mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst_n,
  vga_ram_arbiter_if.slave  bus
);

  logic              adv;
  logic              rd;
  logic              g0;
  logic              g1;
  logic              sel;
  logic              rd_vld;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] pix_q;

  assign adv = bus.ena & ~bus.disp_active;
  assign rd  = rst_n & bus.ena & bus.disp_active;

  vga_wr_rr_arbiter #(
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (adv),
    .req0  (bus.wr0_req),
    .req1  (bus.wr1_req),
    .gnt0  (g0),
    .gnt1  (g1),
    .sel   (sel)
  );

  assign bus.wr0_gnt = g0;
  assign bus.wr1_gnt = g1;

  // RAM port mux: display read, else the granted writer
  always_comb begin
    wr_addr       = sel ? bus.wr1_addr : bus.wr0_addr;
    wr_data       = sel ? bus.wr1_data : bus.wr0_data;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (rd) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = bus.disp_addr;
    end else if (g0 | g1) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = 1'b1;
      bus.ram_addr  = wr_addr;
      bus.ram_wdata = wr_data;
    end
  end

  // Read-valid pipeline and registered pixel output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= 1'b0;
      pix_q  <= '0;
    end else if (bus.ena) begin
      rd_vld <= bus.disp_active;
      pix_q  <= rd_vld ? bus.ram_rdata : '0;
    end
  end

  assign bus.disp_pixel = pix_q;

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// tb_vga_ram_arbiter: random + directed bench with a behavioural model.
// Model tracks owner/tenure/last-granted and a pixel history queue.
module tb_vga_ram_arbiter;

  localparam int AW = 12;
  localparam int DW = 6;
  localparam int MB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  vga_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vga_ram_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bit [DW-1:0] ram [4096];
  bit [DW-1:0] ram_q;
  bit [DW-1:0] exp_mem [4096];

  // Single-port RAM with 1-cycle read latency
  always @(posedge clk) begin
    if (bus.ram_en && bus.ram_we)
      ram[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_en && !bus.ram_we)
      ram_q <= ram[bus.ram_addr];
  end

  assign bus.ram_rdata = ram_q;

  int n_tot  = 0;
  int n_pass = 0;

  int owner;
  int tenure;
  int last;
  bit [DW-1:0] hist[$];
  int mod_g;
  int dut_g;

  int pat [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  int rsm [3]  = '{0, 0, 1};

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  function automatic void model_reset();
    owner  = -1;
    tenure = 0;
    last   = 1;
    hist   = {};
    hist.push_back('0);
    hist.push_back('0);
  endfunction

  function automatic int pick(input bit r0, input bit r1);
    if (owner == 0 && r0) return 0;
    if (owner == 1 && r1) return 1;
    if (r0 && r1) return 1 - last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic void arb_update(input int g,
                                     input bit r0,
                                     input bit r1);
    int n;
    bit oth;
    if (g < 0) begin
      owner  = -1;
      tenure = 0;
      return;
    end
    n    = (g == owner) ? tenure : 0;
    oth  = (g == 0) ? r1 : r0;
    last = g;
    if (n >= MB - 1 && oth) begin
      owner  = 1 - g;
      tenure = 0;
    end else begin
      owner  = g;
      tenure = n + 1;
    end
  endfunction

  task automatic step();
    int g;
    bit rd;
    bit en;
    bit r0;
    bit r1;
    int wa;
    int wd;
    int ea;
    @(negedge clk);
    r0 = bus.wr0_req;
    r1 = bus.wr1_req;
    g  = -1;
    rd = 1'b0;
    if (rst_n && bus.ena) begin
      if (bus.disp_active) rd = 1'b1;
      else g = pick(r0, r1);
    end
    en = rd || (g >= 0);
    wa = (g == 1) ? int'(bus.wr1_addr) : int'(bus.wr0_addr);
    wd = (g == 1) ? int'(bus.wr1_data) : int'(bus.wr0_data);
    ea = rd ? int'(bus.disp_addr) : wa;
    chk("wr0_gnt", int'(bus.wr0_gnt), int'(g == 0));
    chk("wr1_gnt", int'(bus.wr1_gnt), int'(g == 1));
    chk("ram_en", int'(bus.ram_en), int'(en));
    if (en) begin
      chk("ram_we", int'(bus.ram_we), int'(!rd));
      chk("ram_addr", int'(bus.ram_addr), ea);
      if (!rd) chk("ram_wdata", int'(bus.ram_wdata), wd);
    end
    chk("disp_pixel", int'(bus.disp_pixel), int'(hist[0]));
    dut_g = bus.wr1_gnt ? 1 : (bus.wr0_gnt ? 0 : -1);
    mod_g = g;
    @(posedge clk);
    if (rst_n && bus.ena) begin
      hist.push_back(rd ? exp_mem[bus.disp_addr] : '0);
      void'(hist.pop_front());
      if (g >= 0) exp_mem[wa] = DW'(wd);
      if (!rd) arb_update(g, r0, r1);
    end
    #1;
    if (g == 0) begin
      bus.wr0_addr = AW'($urandom_range(0, 63));
      bus.wr0_data = DW'($urandom);
    end
    if (g == 1) begin
      bus.wr1_addr = AW'($urandom_range(0, 63));
      bus.wr1_data = DW'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_gnt0", int'(bus.wr0_gnt), 0);
    chk("rst_gnt1", int'(bus.wr1_gnt), 0);
    chk("rst_ram_en", int'(bus.ram_en), 0);
    chk("rst_pixel", int'(bus.disp_pixel), 0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drive_writer(input int i);
    bit rq;
    rq = (i == 0) ? bus.wr0_req : bus.wr1_req;
    if (rq && mod_g != i) begin
      if ($urandom_range(0, 19) == 0) rq = 1'b0;
    end else begin
      rq = ($urandom_range(0, 99) < 70);
    end
    if (i == 0) bus.wr0_req = rq;
    else bus.wr1_req = rq;
  endtask

  initial begin
    int cnt;
    int mism;
    bus.ena         = 1'b1;
    bus.disp_active = 1'b0;
    bus.disp_addr   = '0;
    bus.wr0_req     = 1'b0;
    bus.wr0_addr    = '0;
    bus.wr0_data    = '0;
    bus.wr1_req     = 1'b0;
    bus.wr1_addr    = 12'h005;
    bus.wr1_data    = 6'h11;
    model_reset();
    mod_g = -1;
    #2;
    do_reset();

    bus.wr1_req = 1'b1;
    #1;
    chk("idle_gnt1", int'(bus.wr1_gnt), 1);
    cnt = 0;
    repeat (10) begin
      step();
      if (dut_g == 1) cnt++;
    end
    bus.wr1_req = 1'b0;
    chk("lone_wr1_cnt", cnt, 10);

    bus.wr0_req  = 1'b1;
    bus.wr0_addr = 12'h010;
    bus.wr0_data = 6'h2A;
    step();
    bus.wr0_req = 1'b0;
    chk("seed_gnt0", dut_g, 0);
    bus.disp_active = 1'b1;
    bus.disp_addr   = 12'h010;
    step();
    bus.disp_active = 1'b0;
    bus.disp_addr   = 12'h020;
    step();
    chk("disp_n2", int'(bus.disp_pixel), 'h2A);
    step();
    chk("disp_blank", int'(bus.disp_pixel), 0);

    do_reset();
    bus.wr0_req = 1'b1;
    bus.wr1_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("cont_beat", dut_g, pat[i]);
    end
    bus.wr0_req = 1'b0;
    bus.wr1_req = 1'b0;
    step();

    do_reset();
    bus.wr0_req = 1'b1;
    bus.wr1_req = 1'b1;
    repeat (2) begin
      step();
      chk("prio_head", dut_g, 0);
    end
    bus.disp_active = 1'b1;
    repeat (3) begin
      step();
      chk("prio_stall", dut_g, -1);
    end
    bus.disp_active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("prio_resume", dut_g, rsm[i]);
    end

    do_reset();
    repeat (2) step();
    bus.ena = 1'b0;
    repeat (5) begin
      step();
      chk("ena_off_en", int'(bus.ram_en), 0);
    end
    bus.ena = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ena_resume", dut_g, rsm[i]);
    end
    bus.wr0_req = 1'b0;
    bus.wr1_req = 1'b0;
    step();

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      if ($urandom_range(0, 15) == 0)
        bus.disp_active = ~bus.disp_active;
      bus.disp_addr = AW'($urandom_range(0, 63));
      bus.ena = ($urandom_range(0, 19) != 0);
      drive_writer(0);
      drive_writer(1);
      step();
    end

    mism = 0;
    for (int a = 0; a < 4096; a++)
      if (ram[a] != exp_mem[a]) mism++;
    chk("ram_contents", mism, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
